// File: rtl/yscaler_linewriter.sv
// Vertical scaler line writer: takes an AXI4-Stream video input, writes each
// line into a ring of line buffers, and counts how many completed lines are
// waiting for the vertical filter.
module yscaler_linewriter #(
  parameter int C_DATA_WIDTH    = 8,
  parameter int C_ADDRESS_WIDTH = 8,
  parameter int C_LINE_NUM      = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          s_axis_tvalid,
  input  logic [C_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                          s_axis_tuser,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic                          wr_en,
  output logic [$clog2(C_LINE_NUM)-1:0] wr_sel,
  output logic [C_ADDRESS_WIDTH-1:0]    wr_addr,
  output logic [C_DATA_WIDTH-1:0]       wr_data,
  input  logic                          line_release,
  output logic [$clog2(C_LINE_NUM):0]   line_count,
  output logic [$clog2(C_LINE_NUM)-1:0] rd_sel,
  output logic [C_ADDRESS_WIDTH:0]      line_width,
  output logic                          frame_start
);

  localparam int LW = $clog2(C_LINE_NUM);
  localparam int AW = C_ADDRESS_WIDTH;
  // Column value once a line has reached the buffer length; it sticks there.
  localparam logic [AW:0] COL_MAX  = {1'b1, {AW{1'b0}}};
  localparam logic [LW:0] FULL_CNT = (LW+1)'(C_LINE_NUM);

  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   col, col_inc;
  logic [LW-1:0] wr_ptr;
  logic [LW:0]   cnt_nxt;
  logic          acc, sof, beat, rel, done_beat;

  // Handshake decode and next line count / state.
  always_comb begin
    acc       = s_axis_tvalid & s_axis_tready;
    sof       = acc & s_axis_tuser;
    beat      = acc & ~s_axis_tuser & (state == WRITE);
    done_beat = beat & s_axis_tlast;
    rel       = line_release & (line_count != '0);
    col_inc   = (col == COL_MAX) ? COL_MAX : col + 1'b1;
    cnt_nxt   = line_count;
    state_nxt = state;
    if (sof) begin
      // A new frame flushes everything, including a coincident release.
      cnt_nxt   = s_axis_tlast ? (LW+1)'(1) : '0;
      state_nxt = WRITE;
    end else begin
      if (done_beat) cnt_nxt = cnt_nxt + 1'b1;
      if (rel)       cnt_nxt = cnt_nxt - 1'b1;
      case (state)
        WRITE:   if (cnt_nxt == FULL_CNT) state_nxt = FULL;
        FULL:    if (cnt_nxt != FULL_CNT) state_nxt = WRITE;
        default: state_nxt = state;
      endcase
    end
  end

  // Ring pointers, column tracking, registered write port and FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      s_axis_tready <= 1'b0;
      col           <= '0;
      wr_ptr        <= '0;
      rd_sel        <= '0;
      line_count    <= '0;
      line_width    <= '0;
      wr_en         <= 1'b0;
      wr_sel        <= '0;
      wr_addr       <= '0;
      wr_data       <= '0;
      frame_start   <= 1'b0;
    end else begin
      wr_en         <= 1'b0;
      frame_start   <= 1'b0;
      state         <= state_nxt;
      line_count    <= cnt_nxt;
      s_axis_tready <= (state_nxt != FULL);
      if (sof) begin
        wr_en       <= 1'b1;
        wr_sel      <= '0;
        wr_addr     <= '0;
        wr_data     <= s_axis_tdata;
        frame_start <= 1'b1;
        rd_sel      <= '0;
        if (s_axis_tlast) begin
          wr_ptr     <= LW'(1);
          col        <= '0;
          line_width <= (AW+1)'(1);
        end else begin
          wr_ptr     <= '0;
          col        <= (AW+1)'(1);
        end
      end else begin
        if (beat) begin
          // Pixels past the buffer length are swallowed without a write.
          if (col != COL_MAX) begin
            wr_en   <= 1'b1;
            wr_sel  <= wr_ptr;
            wr_addr <= col[AW-1:0];
            wr_data <= s_axis_tdata;
          end
          if (s_axis_tlast) begin
            line_width <= col_inc;
            wr_ptr     <= wr_ptr + 1'b1;
            col        <= '0;
          end else begin
            col <= col_inc;
          end
        end
        if (rel) rd_sel <= rd_sel + 1'b1;
      end
    end
  end

endmodule
